// File: rtl/grf_pkg.sv
// Shared definitions for the multi-port general register file.
// Provides default widths and the clear-sequencer state encoding used by
// grf_mp and grf_scoreboard.
package grf_pkg;

  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_PC_W   = 32;

  // Clear sequencer states: normal operation or walking the file to zero.
  typedef enum logic [0:0] {
    GRF_IDLE  = 1'b0,
    GRF_CLEAR = 1'b1
  } grf_state_e;

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard for the register file.
// One pending bit per entry: set by the issue stage, cleared by a committed
// write or by the clear sequencer. Set beats a same-cycle commit so a newly
// issued producer is not lost.
// Ports:
//   clk, reset        clock, async active-low reset
//   set_en_i/addr_i   mark an entry pending (already gated to IDLE by the top)
//   clr_en_i/addr_i   clear-sequencer wipe of one entry
//   commit_i          per write port: write actually committed this cycle
//   commit_addr_i     packed write indices
//   rd_addr_i         packed read indices
//   rd_pending_o      per read port: producer in flight and not bypassable now
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W   = GRF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en_i,
  input  logic [ADDR_W-1:0]        set_addr_i,
  input  logic                     clr_en_i,
  input  logic [ADDR_W-1:0]        clr_addr_i,
  input  logic [NUM_WR-1:0]        commit_i,
  input  logic [NUM_WR*ADDR_W-1:0] commit_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_pending_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;
  logic [ADDR_W-1:0] lk_addr_s;
  logic              lk_hit_s;

  // Next pending state: commits clear first, then a set overrides them.
  always_comb begin
    pending_d = pending_q;
    for (int p = 0; p < NUM_WR; p++) begin
      pending_d[commit_addr_i[p*ADDR_W +: ADDR_W]] =
        pending_d[commit_addr_i[p*ADDR_W +: ADDR_W]] & ~commit_i[p];
    end
    pending_d[set_addr_i] = pending_d[set_addr_i] |
      (set_en_i & ~((ZERO_REG != 0) && (set_addr_i == '0)));
    pending_d[clr_addr_i] = pending_d[clr_addr_i] & ~clr_en_i;
  end

  // Pending bit storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A same-cycle commit to the read index supplies the data via bypass,
  // so the reader need not stall on it.
  always_comb begin
    rd_pending_o = '0;
    lk_addr_s    = '0;
    lk_hit_s     = 1'b0;
    for (int r = 0; r < NUM_RD; r++) begin
      lk_addr_s = rd_addr_i[r*ADDR_W +: ADDR_W];
      lk_hit_s  = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
        lk_hit_s = lk_hit_s |
          (commit_i[p] && (commit_addr_i[p*ADDR_W +: ADDR_W] == lk_addr_s));
      end
      rd_pending_o[r] = pending_q[lk_addr_s] && !lk_hit_s &&
                        !((ZERO_REG != 0) && (lk_addr_s == '0));
    end
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with write-through bypass, fixed-priority
// write ports, pending-write scoreboard, multi-cycle clear and writeback trace.
// Ports:
//   clk, reset              clock, async active-low reset
//   wr_en/addr/data/pc      NUM_WR packed write ports (higher index wins)
//   rd_addr/rd_data         NUM_RD packed combinational read ports
//   rd_pending              per read port hazard flag
//   sb_set_en/sb_set_addr   issue-stage pending mark
//   clr_req/clr_busy        clear request pulse / sequencer running
//   trace_*                 registered per-port record of last cycle's commits
module grf_mp
  import grf_pkg::*;
#(
  parameter int DATA_W   = GRF_DATA_W,
  parameter int ADDR_W   = GRF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_WR*GRF_PC_W-1:0] wr_pc,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pending,
  input  logic                       sb_set_en,
  input  logic [ADDR_W-1:0]          sb_set_addr,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic [NUM_WR-1:0]          trace_valid,
  output logic [NUM_WR*ADDR_W-1:0]   trace_addr,
  output logic [NUM_WR*DATA_W-1:0]   trace_data,
  output logic [NUM_WR*GRF_PC_W-1:0] trace_pc
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  logic [DATA_W-1:0]          mem_q [DEPTH];
  grf_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]          idx_q, idx_d;
  logic                       idle_s;
  logic                       clearing_s;
  logic [NUM_WR-1:0]          commit_s;
  logic                       shadow_s;
  logic [ADDR_W-1:0]          rd_idx_s;
  logic [DATA_W-1:0]          rd_val_s;
  logic [NUM_RD*DATA_W-1:0]   rd_data_s;
  logic [NUM_WR-1:0]          trace_valid_q;
  logic [NUM_WR*ADDR_W-1:0]   trace_addr_q;
  logic [NUM_WR*DATA_W-1:0]   trace_data_q;
  logic [NUM_WR*GRF_PC_W-1:0] trace_pc_q;

  assign idle_s     = (state_q == GRF_IDLE);
  assign clearing_s = (state_q == GRF_CLEAR);
  assign clr_busy   = clearing_s;

  // Write resolution: a port commits only if no higher port targets the
  // same index, the sequencer is idle and the index is writable.
  always_comb begin
    commit_s = '0;
    shadow_s = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      shadow_s = 1'b0;
      for (int q = p + 1; q < NUM_WR; q++) begin
        shadow_s = shadow_s | (wr_en[q] &&
          (wr_addr[q*ADDR_W +: ADDR_W] == wr_addr[p*ADDR_W +: ADDR_W]));
      end
      commit_s[p] = wr_en[p] && idle_s && !shadow_s &&
        !((ZERO_REG != 0) && (wr_addr[p*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Read muxes; commits are unique per index so at most one bypass matches.
  // During a clear no commit exists, so reads fall back to stored values.
  always_comb begin
    rd_data_s = '0;
    rd_idx_s  = '0;
    rd_val_s  = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_idx_s = rd_addr[r*ADDR_W +: ADDR_W];
      rd_val_s = mem_q[rd_idx_s];
      for (int p = 0; p < NUM_WR; p++) begin
        rd_val_s = (commit_s[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_idx_s))
                 ? wr_data[p*DATA_W +: DATA_W] : rd_val_s;
      end
      rd_val_s = ((ZERO_REG != 0) && (rd_idx_s == '0)) ? '0 : rd_val_s;
      rd_data_s[r*DATA_W +: DATA_W] = rd_val_s;
    end
  end

  assign rd_data = rd_data_s;

  // Clear sequencer next state: walk idx from 0 to DEPTH-1, one entry per cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      GRF_IDLE: begin
        if (clr_req) begin
          state_d = GRF_CLEAR;
          idx_d   = '0;
        end else begin
          state_d = GRF_IDLE;
        end
      end
      GRF_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = GRF_IDLE;
        end else begin
          state_d = GRF_CLEAR;
        end
      end
      default: begin
        state_d = GRF_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Clear sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GRF_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Register array: clear wipes one entry per cycle, otherwise commit writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clearing_s) begin
      mem_q[idx_q] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (commit_s[p]) begin
          mem_q[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Writeback trace: records this cycle's commits for the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_valid_q <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
      trace_pc_q    <= '0;
    end else begin
      trace_valid_q <= commit_s;
      for (int p = 0; p < NUM_WR; p++) begin
        if (commit_s[p]) begin
          trace_addr_q[p*ADDR_W +: ADDR_W]     <= wr_addr[p*ADDR_W +: ADDR_W];
          trace_data_q[p*DATA_W +: DATA_W]     <= wr_data[p*DATA_W +: DATA_W];
          trace_pc_q[p*GRF_PC_W +: GRF_PC_W]   <= wr_pc[p*GRF_PC_W +: GRF_PC_W];
        end
      end
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;
  assign trace_pc    = trace_pc_q;

  grf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk           (clk),
    .reset         (reset),
    .set_en_i      (sb_set_en && idle_s),
    .set_addr_i    (sb_set_addr),
    .clr_en_i      (clearing_s),
    .clr_addr_i    (idx_q),
    .commit_i      (commit_s),
    .commit_addr_i (wr_addr),
    .rd_addr_i     (rd_addr),
    .rd_pending_o  (rd_pending)
  );

endmodule
